// File: rtl/monolith_pkg.sv
// Shared types and helpers for the Monolith permutation datapath over M31.
package monolith_pkg;

  localparam int unsigned M31_WIDTH = 31;
  localparam logic [M31_WIDTH-1:0] M31_P = 31'h7FFF_FFFF;

  typedef logic [M31_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } bars_state_e;

  // Number of S-box limbs per word; the last limb takes whatever bits remain.
  function automatic int unsigned limb_count(input int unsigned word_width,
                                             input int unsigned limb_width);
    return (word_width + limb_width - 1) / limb_width;
  endfunction

endpackage

// File: rtl/mod_reduction_inout_if.sv
// Value-in / reduced-value-out bundle shared by the modular reducers.
interface mod_reduction_inout_if #(
  parameter int unsigned W = 31
);
  logic [W-1:0] value;
  logic [W-1:0] reduced;

  modport reducer (input value, output reduced);
  modport user (output value, input reduced);
endinterface

// File: rtl/m31_mod_reduce.sv
// Canonical reduction of a W-bit word modulo 2^W-1: the all-ones pattern folds to zero.
module m31_mod_reduce (
  mod_reduction_inout_if.reducer io
);
  assign io.reduced = (&io.value) ? '0 : io.value;
endmodule

// File: rtl/monolith_bar_word.sv
// One Bars word: splits the word into limbs LSB-first and S-boxes each limb.
module monolith_bar_word
  import monolith_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = M31_WIDTH,
  parameter int unsigned LIMB_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);

  localparam int unsigned N_LIMBS = limb_count(WORD_WIDTH, LIMB_WIDTH);
  localparam int unsigned LAST_W  = WORD_WIDTH - (N_LIMBS - 1) * LIMB_WIDTH;

  for (genvar i = 0; i < N_LIMBS; i++) begin : g_limb
    localparam int unsigned LW = (i == N_LIMBS - 1) ? LAST_W : LIMB_WIDTH;
    monolith_sbox #(.W(LW)) u_sbox (
      .x (word_in[i*LIMB_WIDTH +: LW]),
      .y (word_out[i*LIMB_WIDTH +: LW])
    );
  end

endmodule

// File: rtl/monolith_sbox.sv
// Monolith limb S-box: y = x ^ (~rotl1 & rotl2 & rotl3), result rotl1(y), rotations within W bits.
module monolith_sbox #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned r);
    return (v << r) | (v >> (W - r));
  endfunction

  logic [W-1:0] chi;

  assign chi = x ^ (~rotl(x, 1) & rotl(x, 2) & rotl(x, 3));
  assign y   = rotl(chi, 1);

endmodule

// File: rtl/monolith_bars_seq.sv
// Time-multiplexed Bars layer: S-boxes LANES leading words per cycle in place, then presents the reduced state.
module monolith_bars_seq
  import monolith_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = M31_WIDTH,
  parameter int unsigned STATE_SIZE   = 16,
  parameter int unsigned BAR_OP_COUNT = 8,
  parameter int unsigned LANES        = 2,
  parameter int unsigned LIMB_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] state_in  [0:STATE_SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] state_out [0:STATE_SIZE-1]
);

  localparam int unsigned IDX_W = $clog2(BAR_OP_COUNT + 1);
  localparam int unsigned SEL_W = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BAR_OP_COUNT - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

  if ((LANES == 0) || (BAR_OP_COUNT % LANES != 0)) begin : g_bad_lanes
    $error("monolith_bars_seq: LANES must divide BAR_OP_COUNT");
  end

  bars_state_e           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  drain_q;
  logic                  run_q;
  logic [WORD_WIDTH-1:0] st_q     [0:STATE_SIZE-1];
  logic [SEL_W-1:0]      sel      [0:LANES-1];
  logic [WORD_WIDTH-1:0] lane_out [0:LANES-1];

  // Window of LANES words starting at idx feeds the S-box lanes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sel[l] = SEL_W'(idx_q) + SEL_W'(l);
    monolith_bar_word #(
      .WORD_WIDTH (WORD_WIDTH),
      .LIMB_WIDTH (LIMB_WIDTH)
    ) u_bar (
      .word_in  (st_q[sel[l]]),
      .word_out (lane_out[l])
    );
  end

  // Every registered word, including pass-through words, leaves in canonical form.
  for (genvar w = 0; w < STATE_SIZE; w++) begin : g_reduce
    mod_reduction_inout_if #(.W(WORD_WIDTH)) red_if ();
    m31_mod_reduce u_red (.io(red_if));
    assign red_if.value = st_q[w];
    assign state_out[w] = red_if.reduced;
  end

  // run_q holds ready low for the first cycle after reset; DONE forwards out_ready for back-to-back.
  assign in_ready = !reset && run_q &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready));

  // Sequencer: capture, LANES-wide in-place S-box sweep, one drain cycle, then hold until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      run_q     <= 1'b0;
      out_valid <= 1'b0;
      st_q      <= '{default: '0};
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_q    <= state_in;
            idx_q   <= '0;
            drain_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (drain_q) begin
            drain_q   <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
              st_q[sel[l]] <= lane_out[l];
            end
            if (idx_q == LAST_IDX) begin
              drain_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_STEP;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st_q    <= state_in;
              idx_q   <= '0;
              drain_q <= 1'b0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
